mp_adder_arbiter: RTL and testbench
===================================

Name: mp_adder_arbiter

Overview:
- Shares a single mp_adder instance between NREQ independent requesters using round-robin arbitration.
- Captures the winner's operands and sequences the adder's start/done handshake.
- Returns the (OPERAND_WIDTH+1)-bit sum with a per-requester acknowledge.
- Includes a watchdog that aborts a hung addition. Sits between the UART command front-ends or other clients and the shared adder datapath.

Parameters:
- OPERAND_WIDTH, 512, operand width in bits; the sum is OPERAND_WIDTH+1 bits.
- NREQ, 4, number of requesters (at least 2).
- TIMEOUT_CYCLES, 256, maximum cycles spent in S_WAIT before abort; 0 disables the watchdog.

Ports:
- iClk  in  1  clock.
- iRst  in  1  synchronous, active-high reset.
- iReq  in  NREQ  level request per requester; held until the matching oAck.
- iOpA  in  NREQ*OPERAND_WIDTH  operand A; requester i occupies [i*OPERAND_WIDTH +: OPERAND_WIDTH].
- iOpB  in  NREQ*OPERAND_WIDTH  operand B; same packing as iOpA.
- oGnt  out  NREQ  one-hot; high from operand capture through the oAck cycle.
- oAck  out  NREQ  one-cycle pulse; result is valid for requester i.
- oRes  out  OPERAND_WIDTH+1  sum; valid during oAck and held until the next oAck.
- oErr  out  1  high together with oAck when the transaction timed out.
- oAddStart  out  1  one-cycle start pulse to the adder.
- oAddOpA  out  OPERAND_WIDTH  registered operand A; stable from oAddStart until the response.
- oAddOpB  out  OPERAND_WIDTH  registered operand B; same stability rule.
- iAddRes  in  OPERAND_WIDTH+1  adder sum.
- iAddDone  in  1  adder completion pulse.

Behaviour:
- Reset values: all outputs 0, state S_IDLE, round-robin pointer rPtr=0, watchdog counter 0.
- Reset mid-transaction: next cycle is S_IDLE with oGnt=0 and oAddStart=0. No oAck is issued for the aborted transaction.

States:
- S_IDLE:
  - If iReq is non-zero, select the first asserted index searching rPtr, rPtr+1, ... modulo NREQ.
  - Register the selected operands into oAddOpA/oAddOpB, set oGnt one-hot, go to S_START.
  - Otherwise stay in S_IDLE.
- S_START: oAddStart=1 for exactly this cycle; clear the watchdog counter; go to S_WAIT.
- S_WAIT:
  - If iAddDone=1: register oRes<=iAddRes, oErr<=0, go to S_RESP.
  - Else if TIMEOUT_CYCLES!=0 and counter==TIMEOUT_CYCLES-1: oRes<=0, oErr<=1, go to S_RESP.
  - Else increment the counter.
- S_RESP: oAck[g]=1 for one cycle; rPtr<=(g+1) mod NREQ; go to S_IDLE. oGnt clears on exit.

Timing, with iReq sampled in S_IDLE at cycle T:
- oGnt, operands and oAddStart at T+1.
- iAddDone sampled at cycle D gives oAck/oRes at D+1.
- Earliest next grant is D+3.
- Per-transaction overhead beyond adder latency: 3 cycles.

Handshake rules:
- The requester must drop iReq[i] in the cycle after oAck[i]; otherwise it is treated as a new request.
- iReq dropped while granted: the transaction still completes and is acknowledged.
- Operand changes after capture are ignored.

Boundary cases:
- iAddDone outside S_WAIT is ignored, including a stale done after a timeout.
- iAddDone in the same cycle as watchdog expiry: done wins, oErr=0.
- Simultaneous requests: exactly one grant per transaction; oGnt and oAck are always one-hot or zero.
- Fairness: a continuously requesting client waits at most NREQ-1 other transactions.
- Width: the watchdog counter is $clog2(TIMEOUT_CYCLES+1) bits. oRes is passed through unmodified, carry in the MSB.

Test Plan:
1. Setup: behavioral adder with 17-cycle latency. Stimulus: iReq=0001, A=1, B=2 -> oGnt=0001 and oAddStart pulse 1 cycle later; oAck=0001 with oRes=3, oErr=0, exactly 1 cycle after iAddDone.
2. Stimulus: requester 2 with A=B=2^512-1 -> oRes=2^513-2 (bit 512=1, bits 511:1 all ones, bit 0=0); oAck=0100.
3. Stimulus: iReq=1111 held continuously for 8 transactions -> grant order 0,1,2,3,0,1,2,3; never two bits in oGnt; oAddStart count=8.
4. Stimulus: serve requester 1 (rPtr=2), then iReq=1010 -> requester 3 granted before 1; then requester 1, with rPtr=0 afterwards.
5. Stimulus: adder never asserts done, TIMEOUT_CYCLES=256 -> oAck after 256 S_WAIT cycles with oErr=1, oRes=0. A late iAddDone is ignored, and the next request completes normally with oErr=0.
6. Stimulus: iRst pulsed while in S_WAIT for requester 1 -> next cycle oGnt=0, oAck=0, oAddStart=0, rPtr=0. A subsequent iAddDone produces no oAck, and a fresh iReq=0010 is served normally.

Source files
------------

// File: rtl/mp_adder_arbiter_if.sv
// Request/response bus shared by the arbiter, its requesters and the adder datapath.
// The slave side is the arbiter; the master side is everything around it.
interface mp_adder_arbiter_if #(
    parameter int OPERAND_WIDTH = 512,
    parameter int NREQ          = 4
);
    logic [NREQ-1:0]               iReq;
    logic [NREQ*OPERAND_WIDTH-1:0] iOpA;
    logic [NREQ*OPERAND_WIDTH-1:0] iOpB;
    logic [NREQ-1:0]               oGnt;
    logic [NREQ-1:0]               oAck;
    logic [OPERAND_WIDTH:0]        oRes;
    logic                          oErr;
    logic                          oAddStart;
    logic [OPERAND_WIDTH-1:0]      oAddOpA;
    logic [OPERAND_WIDTH-1:0]      oAddOpB;
    logic [OPERAND_WIDTH:0]        iAddRes;
    logic                          iAddDone;

    modport slave (
        input  iReq, iOpA, iOpB, iAddRes, iAddDone,
        output oGnt, oAck, oRes, oErr, oAddStart, oAddOpA, oAddOpB
    );

    modport master (
        output iReq, iOpA, iOpB, iAddRes, iAddDone,
        input  oGnt, oAck, oRes, oErr, oAddStart, oAddOpA, oAddOpB
    );
endinterface

// File: rtl/mp_adder_arbiter.sv
// Round-robin front end that shares one multi-precision adder between NREQ clients,
// sequencing its start/done handshake and aborting a hung addition with a watchdog.
//
// state   | meaning
// S_IDLE  | no transaction; pick next requester from the round-robin pointer
// S_START | one-cycle start pulse to the adder, watchdog cleared
// S_WAIT  | waiting for adder done or watchdog expiry
// S_RESP  | one-cycle acknowledge to the granted requester, pointer advances
module mp_adder_arbiter #(
    parameter int OPERAND_WIDTH  = 512,
    parameter int NREQ           = 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                iClk,
    input  logic                iRst,
    mp_adder_arbiter_if.slave   bus
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

    state_t                   state_q, state_d;
    logic [PW-1:0]            ptr_q, ptr_d;
    logic [PW-1:0]            idx_q, idx_d;
    logic [NREQ-1:0]          gnt_q, gnt_d;
    logic [NREQ-1:0]          ack_q, ack_d;
    logic [OPERAND_WIDTH:0]   res_q, res_d;
    logic                     err_q, err_d;
    logic                     start_q, start_d;
    logic [OPERAND_WIDTH-1:0] opa_q, opa_d;
    logic [OPERAND_WIDTH-1:0] opb_q, opb_d;
    logic [CW-1:0]            wdog_q, wdog_d;

    logic [PW-1:0]            cand;
    logic [PW-1:0]            sel_idx;
    logic                     sel_found;
    logic                     wdog_hit;

    // First asserted request at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        cand      = '0;
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = PW'((int'(ptr_q) + k) % NREQ);
            if (!sel_found && bus.iReq[cand]) begin
                sel_found = 1'b1;
                sel_idx   = cand;
            end
        end
    end

    assign wdog_hit = (TIMEOUT_CYCLES != 0) && (int'(wdog_q) == TIMEOUT_CYCLES - 1);

    always_ff @(posedge iClk) begin
        if (iRst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sel_found) state_d = S_START;
            S_START: state_d = S_WAIT;
            S_WAIT:  if (bus.iAddDone || wdog_hit) state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        res_d   = res_q;
        err_d   = err_q;
        start_d = 1'b0;
        opa_d   = opa_q;
        opb_d   = opb_q;
        wdog_d  = wdog_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    idx_d   = sel_idx;
                    gnt_d   = NREQ'(1) << sel_idx;
                    start_d = 1'b1;
                    for (int i = 0; i < NREQ; i++) begin
                        if (sel_idx == PW'(i)) begin
                            opa_d = bus.iOpA[i*OPERAND_WIDTH +: OPERAND_WIDTH];
                            opb_d = bus.iOpB[i*OPERAND_WIDTH +: OPERAND_WIDTH];
                        end
                    end
                end
            end
            S_START: wdog_d = '0;
            S_WAIT: begin
                // A done arriving in the expiry cycle still counts as success.
                if (bus.iAddDone) begin
                    res_d = bus.iAddRes;
                    err_d = 1'b0;
                    ack_d = gnt_q;
                end else if (wdog_hit) begin
                    res_d = '0;
                    err_d = 1'b1;
                    ack_d = gnt_q;
                end else begin
                    wdog_d = wdog_q + CW'(1);
                end
            end
            S_RESP: begin
                gnt_d = '0;
                ptr_d = PW'((int'(idx_q) + 1) % NREQ);
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            ptr_q   <= '0;
            idx_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            start_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            wdog_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            res_q   <= res_d;
            err_q   <= err_d;
            start_q <= start_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            wdog_q  <= wdog_d;
        end
    end

    assign bus.oGnt      = gnt_q;
    assign bus.oAck      = ack_q;
    assign bus.oRes      = res_q;
    assign bus.oErr      = err_q;
    assign bus.oAddStart = start_q;
    assign bus.oAddOpA   = opa_q;
    assign bus.oAddOpB   = opb_q;
endmodule

// File: tb/tb_mp_adder_arbiter.sv
// Bench for mp_adder_arbiter: behavioural adder with programmable latency,
// round-robin reference pointer and sum model computed with plain arithmetic.
`timescale 1ns/1ps
module tb_mp_adder_arbiter;
    localparam int W  = 512;
    localparam int N  = 4;
    localparam int TO = 256;

    logic iClk = 1'b0;
    logic iRst;
    always #5 iClk = ~iClk;

    mp_adder_arbiter_if #(.OPERAND_WIDTH(W), .NREQ(N)) bus ();

    mp_adder_arbiter #(.OPERAND_WIDTH(W), .NREQ(N), .TIMEOUT_CYCLES(TO)) dut (
        .iClk (iClk),
        .iRst (iRst),
        .bus  (bus)
    );

    logic [W-1:0] opa [N];
    logic [W-1:0] opb [N];
    for (genvar g = 0; g < N; g++) begin : g_pack
        assign bus.iOpA[g*W +: W] = opa[g];
        assign bus.iOpB[g*W +: W] = opb[g];
    end

    int n_tests = 0;
    int n_fail  = 0;
    int ref_ptr = 0;

    // Behavioural adder: done pulses 'lat' cycles after a sampled start.
    logic       mdl_done   = 1'b0;
    logic [W:0] mdl_sum    = '0;
    int         mdl_cnt    = 0;
    bit         mdl_pend   = 1'b0;
    bit         adder_en   = 1'b1;
    int         lat        = 17;
    int         start_cnt  = 0;
    logic       stray_done = 1'b0;
    logic [W:0] stray_res  = '0;

    assign bus.iAddDone = mdl_done | stray_done;
    assign bus.iAddRes  = stray_done ? stray_res : mdl_sum;

    always @(posedge iClk) begin
        mdl_done <= 1'b0;
        if (bus.oAddStart) start_cnt <= start_cnt + 1;
        if (bus.oAddStart && adder_en) begin
            mdl_cnt  <= lat;
            mdl_pend <= 1'b1;
            mdl_sum  <= {1'b0, bus.oAddOpA} + {1'b0, bus.oAddOpB};
        end else if (mdl_pend) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
                mdl_done <= 1'b1;
                mdl_pend <= 1'b0;
            end
        end
    end

    logic [N-1:0] obs_gnt, obs_ack, obs_gnt_after;
    logic [W:0]   obs_res;
    logic         obs_err, obs_start;
    logic [W-1:0] obs_capa, obs_capb;
    bit           obs_clean, obs_done_prev;
    int           obs_dist, obs_wait;

    task automatic tick();
        @(negedge iClk);
    endtask

    function automatic logic [W-1:0] rand_w();
        logic [W-1:0] v;
        for (int j = 0; j < W/32; j++) v[j*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic int ref_pick(input logic [N-1:0] req);
        for (int k = 0; k < N; k++)
            if (req[(ref_ptr + k) % N]) return (ref_ptr + k) % N;
        return -1;
    endfunction

    function automatic logic [W:0] ref_sum(input int i);
        return {1'b0, opa[i]} + {1'b0, opb[i]};
    endfunction

    // Runs one transaction from the current iReq and records what the DUT did.
    // mode: 0 drop the acked bit, 1 hold iReq, 2 drop all requests.
    task automatic run_txn(input int mode, input bit drop, input bit scramble, output bit ok);
        int  n;
        bit  prev_done;
        ok = 1'b0;
        obs_gnt = '0; obs_ack = '0; obs_res = '0; obs_err = 1'b0; obs_start = 1'b0;
        obs_clean = 1'b1; obs_done_prev = 1'b0; obs_dist = 0; obs_gnt_after = '1;
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.oGnt == '0 && n < 40);
        obs_wait = n;
        if (bus.oGnt == '0) return;
        obs_gnt   = bus.oGnt;
        obs_start = bus.oAddStart;
        obs_capa  = bus.oAddOpA;
        obs_capb  = bus.oAddOpB;
        if (!$onehot(bus.oGnt)) obs_clean = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (obs_gnt[i]) begin
                if (drop) bus.iReq[i] = 1'b0;
                if (scramble) begin
                    opa[i] = rand_w();
                    opb[i] = rand_w();
                end
            end
        end
        prev_done = 1'b0;
        while (bus.oAck == '0 && obs_dist < TO + 40) begin
            prev_done = bus.iAddDone;
            tick();
            obs_dist++;
            if (bus.oGnt !== obs_gnt || bus.oAddStart !== 1'b0 ||
                bus.oAddOpA !== obs_capa || bus.oAddOpB !== obs_capb) obs_clean = 1'b0;
        end
        if (bus.oAck == '0) return;
        obs_ack       = bus.oAck;
        obs_res       = bus.oRes;
        obs_err       = bus.oErr;
        obs_done_prev = prev_done;
        if (!$onehot(bus.oAck)) obs_clean = 1'b0;
        if (mode == 0)      bus.iReq = bus.iReq & ~bus.oAck;
        else if (mode == 2) bus.iReq = '0;
        tick();
        obs_gnt_after = bus.oGnt;
        if (bus.oAck !== '0) obs_clean = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        iRst = 1'b1;
        bus.iReq = '0;
        repeat (3) tick();
        n_tests++;
        if (bus.oGnt !== '0 || bus.oAck !== '0 || bus.oErr !== 1'b0 || bus.oAddStart !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: gnt=%b ack=%b err=%b start=%b, expected all 0",
                     bus.oGnt, bus.oAck, bus.oErr, bus.oAddStart);
        end
        n_tests++;
        if (bus.oRes !== '0 || bus.oAddOpA !== '0 || bus.oAddOpB !== '0) begin
            n_fail++;
            $display("FAIL reset_data: res/opA/opB not zero (res=%h)", bus.oRes);
        end
        bus.iReq = 4'b1111;
        tick();
        tick();
        n_tests++;
        if (bus.oGnt !== '0) begin
            n_fail++;
            $display("FAIL reset_holds: gnt=%b while in reset, expected 0000", bus.oGnt);
        end
        bus.iReq = '0;
        iRst = 1'b0;
        ref_ptr = 0;
        tick();
    endtask

    task automatic test_basic();
        bit ok;
        lat = 17; adder_en = 1'b1;
        opa[0] = W'(1); opb[0] = W'(2);
        bus.iReq = 4'b0001;
        run_txn(0, 1'b0, 1'b0, ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL basic_complete: no grant/ack within bound"); end
        n_tests++;
        if (obs_gnt !== 4'b0001 || obs_wait != 1) begin
            n_fail++;
            $display("FAIL basic_grant: gnt=%b after %0d cycles, expected 0001 after 1", obs_gnt, obs_wait);
        end
        n_tests++;
        if (obs_start !== 1'b1 || !obs_clean) begin
            n_fail++;
            $display("FAIL basic_start: start=%b clean=%0d, expected single start pulse with grant", obs_start, obs_clean);
        end
        n_tests++;
        if (obs_ack !== 4'b0001 || !obs_done_prev) begin
            n_fail++;
            $display("FAIL basic_ack: ack=%b done_prev=%0d, expected 0001 one cycle after done", obs_ack, obs_done_prev);
        end
        n_tests++;
        if (obs_res !== (W+1)'(3) || obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_result: res=%0d err=%b, expected 3 err 0", obs_res, obs_err);
        end
        n_tests++;
        if (obs_dist != lat + 2 || obs_gnt_after !== '0) begin
            n_fail++;
            $display("FAIL basic_timing: grant->ack=%0d gnt_after=%b, expected %0d and 0000", obs_dist, obs_gnt_after, lat + 2);
        end
        ref_ptr = 1;
    endtask

    task automatic test_wide();
        bit ok;
        logic [W:0] e;
        opa[2] = '1; opb[2] = '1;
        e = '1; e[0] = 1'b0;
        bus.iReq = 4'b0100;
        run_txn(0, 1'b0, 1'b0, ok);
        n_tests++;
        if (!ok || obs_ack !== 4'b0100 || obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL wide_ack: ok=%0d ack=%b err=%b, expected 0100 err 0", ok, obs_ack, obs_err);
        end
        n_tests++;
        if (obs_res !== e) begin
            n_fail++;
            $display("FAIL wide_sum: res=%h, expected %h", obs_res, e);
        end
        n_tests++;
        if (obs_capa !== opa[2] || obs_capb !== opb[2]) begin
            n_fail++;
            $display("FAIL wide_capture: captured operands differ from requester 2");
        end
        ref_ptr = 3;
    endtask

    task automatic test_back_to_back();
        bit ok;
        int idx, sc0;
        logic [N-1:0] eg;
        logic [W:0] er;
        for (int i = 0; i < N; i++) begin opa[i] = rand_w(); opb[i] = rand_w(); end
        sc0 = start_cnt;
        bus.iReq = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            lat = $urandom_range(1, 5);
            idx = ref_pick(bus.iReq);
            eg  = N'(1) << idx;
            er  = ref_sum(idx);
            run_txn((k == 7) ? 2 : 1, 1'b0, 1'b0, ok);
            n_tests++;
            if (!ok || obs_gnt !== eg || obs_ack !== eg || obs_res !== er || obs_err !== 1'b0 || !obs_clean) begin
                n_fail++;
                $display("FAIL rr_txn%0d: ok=%0d gnt=%b ack=%b err=%b clean=%0d, expected gnt/ack %b", k, ok, obs_gnt, obs_ack, obs_err, obs_clean, eg);
            end
            if (k > 0) begin
                n_tests++;
                if (obs_wait != 1) begin
                    n_fail++;
                    $display("FAIL rr_gap%0d: next grant after %0d cycles, expected 1", k, obs_wait);
                end
            end
            ref_ptr = (idx + 1) % N;
        end
        n_tests++;
        if (start_cnt - sc0 != 8) begin
            n_fail++;
            $display("FAIL rr_starts: %0d start pulses, expected 8", start_cnt - sc0);
        end
    endtask

    task automatic test_rr_skip();
        bit ok;
        int exp_seq [4] = '{1, 3, 1, 3};
        logic [N-1:0] req_seq [4] = '{4'b0010, 4'b1010, 4'b0000, 4'b1011};
        lat = 4;
        for (int k = 0; k < 4; k++) begin
            if (k != 2) bus.iReq = req_seq[k];
            n_tests++;
            if (ref_pick(bus.iReq) != exp_seq[k]) begin
                n_fail++;
                $display("FAIL skip_model%0d: reference picks %0d, expected %0d", k, ref_pick(bus.iReq), exp_seq[k]);
            end
            run_txn((k == 3) ? 2 : 0, 1'b0, 1'b0, ok);
            n_tests++;
            if (!ok || obs_gnt !== N'(1) << exp_seq[k] || obs_ack !== N'(1) << exp_seq[k]) begin
                n_fail++;
                $display("FAIL skip_grant%0d: gnt=%b ack=%b, expected requester %0d", k, obs_gnt, obs_ack, exp_seq[k]);
            end
            ref_ptr = (exp_seq[k] + 1) % N;
        end
    endtask

    task automatic test_timeout();
        bit ok, saw_ack;
        int idx;
        logic [W:0] er;
        adder_en = 1'b0;
        bus.iReq = 4'b0001;
        run_txn(0, 1'b0, 1'b0, ok);
        n_tests++;
        if (!ok || obs_ack !== 4'b0001 || obs_err !== 1'b1 || obs_res !== '0) begin
            n_fail++;
            $display("FAIL to_abort: ok=%0d ack=%b err=%b res=%h, expected 0001 err 1 res 0", ok, obs_ack, obs_err, obs_res);
        end
        n_tests++;
        if (obs_dist != TO + 1 || !obs_clean) begin
            n_fail++;
            $display("FAIL to_length: grant->ack=%0d clean=%0d, expected %0d", obs_dist, obs_clean, TO + 1);
        end
        ref_ptr = 1;
        stray_res  = {1'b1, rand_w()};
        stray_done = 1'b1;
        tick();
        stray_done = 1'b0;
        saw_ack = 1'b0;
        repeat (5) begin
            tick();
            if (bus.oAck !== '0) saw_ack = 1'b1;
        end
        n_tests++;
        if (saw_ack || bus.oRes !== '0) begin
            n_fail++;
            $display("FAIL to_late_done: ack seen=%0d res=%h, expected no ack and res 0", saw_ack, bus.oRes);
        end
        adder_en = 1'b1;
        lat = 17;
        opa[2] = rand_w(); opb[2] = rand_w();
        er = ref_sum(2);
        bus.iReq = 4'b0100;
        run_txn(0, 1'b0, 1'b0, ok);
        n_tests++;
        if (!ok || obs_ack !== 4'b0100 || obs_err !== 1'b0 || obs_res !== er) begin
            n_fail++;
            $display("FAIL to_recover: ack=%b err=%b res=%h, expected 0100 err 0 res %h", obs_ack, obs_err, obs_res, er);
        end
        ref_ptr = 3;
        lat = TO - 1;
        opa[3] = rand_w(); opb[3] = rand_w();
        er = ref_sum(3);
        bus.iReq = 4'b1000;
        run_txn(0, 1'b0, 1'b0, ok);
        n_tests++;
        if (!ok || obs_err !== 1'b0 || obs_res !== er || obs_dist != TO + 1) begin
            n_fail++;
            $display("FAIL to_tie: err=%b dist=%0d res=%h, expected err 0 dist %0d res %h", obs_err, obs_dist, obs_res, TO + 1, er);
        end
        ref_ptr = 0;
        lat = TO;
        idx = ref_pick(4'b0001);
        bus.iReq = 4'b0001;
        run_txn(0, 1'b0, 1'b0, ok);
        n_tests++;
        if (!ok || obs_ack !== N'(1) << idx || obs_err !== 1'b1 || obs_res !== '0) begin
            n_fail++;
            $display("FAIL to_wins: ack=%b err=%b res=%h, expected timeout on requester %0d", obs_ack, obs_err, obs_res, idx);
        end
        saw_ack = 1'b0;
        repeat (4) begin
            tick();
            if (bus.oAck !== '0) saw_ack = 1'b1;
        end
        n_tests++;
        if (saw_ack) begin
            n_fail++;
            $display("FAIL to_stale_done: ack seen after timeout, expected none");
        end
        ref_ptr = 1;
        lat = 17;
    endtask

    task automatic test_reset_mid();
        bit ok, saw_ack, saw_done;
        int n;
        logic [W:0] er;
        opa[2] = rand_w(); opb[2] = rand_w();
        bus.iReq = 4'b0100;
        run_txn(0, 1'b0, 1'b0, ok);
        ref_ptr = 3;
        bus.iReq = 4'b0010;
        n = 0;
        do begin tick(); n++; end while (bus.oGnt == '0 && n < 40);
        n_tests++;
        if (bus.oGnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_pre_grant: gnt=%b, expected 0010", bus.oGnt);
        end
        repeat (5) tick();
        iRst = 1'b1;
        bus.iReq = '0;
        tick();
        iRst = 1'b0;
        ref_ptr = 0;
        n_tests++;
        if (bus.oGnt !== '0 || bus.oAck !== '0 || bus.oAddStart !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid: gnt=%b ack=%b start=%b, expected all 0", bus.oGnt, bus.oAck, bus.oAddStart);
        end
        saw_ack = 1'b0; saw_done = 1'b0;
        repeat (30) begin
            tick();
            if (bus.iAddDone) saw_done = 1'b1;
            if (bus.oAck !== '0) saw_ack = 1'b1;
        end
        n_tests++;
        if (!saw_done || saw_ack) begin
            n_fail++;
            $display("FAIL rst_stale: done seen=%0d ack seen=%0d, expected done 1 ack 0", saw_done, saw_ack);
        end
        for (int k = 0; k < 2; k++) begin
            if (k == 0) bus.iReq = 4'b1010;
            n = ref_pick(bus.iReq);
            er = ref_sum(n);
            run_txn(0, 1'b0, 1'b0, ok);
            n_tests++;
            if (!ok || obs_ack !== N'(1) << n || obs_res !== er || obs_err !== 1'b0) begin
                n_fail++;
                $display("FAIL rst_after%0d: ack=%b err=%b, expected requester %0d", k, obs_ack, obs_err, n);
            end
            ref_ptr = (n + 1) % N;
        end
    endtask

    task automatic test_random();
        bit ok, drop, scr;
        int idx;
        logic [N-1:0] eg;
        logic [W:0] er;
        logic [W-1:0] ea, eb;
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < N; i++) begin opa[i] = rand_w(); opb[i] = rand_w(); end
            lat  = $urandom_range(1, 12);
            drop = 1'($urandom_range(0, 1));
            scr  = 1'($urandom_range(0, 1));
            bus.iReq = N'($urandom_range(1, (1 << N) - 1));
            idx = ref_pick(bus.iReq);
            eg = N'(1) << idx;
            er = ref_sum(idx);
            ea = opa[idx];
            eb = opb[idx];
            run_txn(0, drop, scr, ok);
            n_tests++;
            if (!ok || obs_gnt !== eg || obs_ack !== eg || obs_err !== 1'b0 || !obs_clean) begin
                n_fail++;
                $display("FAIL rand%0d_ctrl: gnt=%b ack=%b err=%b clean=%0d, expected %b", k, obs_gnt, obs_ack, obs_err, obs_clean, eg);
            end
            n_tests++;
            if (obs_res !== er || obs_capa !== ea || obs_capb !== eb) begin
                n_fail++;
                $display("FAIL rand%0d_data: res=%h, expected %h", k, obs_res, er);
            end
            ref_ptr = (idx + 1) % N;
        end
        bus.iReq = '0;
        tick();
    endtask

    initial begin
        iRst = 1'b1;
        bus.iReq = '0;
        for (int i = 0; i < N; i++) begin opa[i] = '0; opb[i] = '0; end
        test_reset();
        test_basic();
        test_wide();
        test_back_to_back();
        test_rr_skip();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
